// File: rtl/axistream_forwarder_pl_pkg.sv
// Shared definitions for the pipelined AXI Stream packet forwarder:
// state encoding, CLOG2 helper and skid FIFO depth derivation.
`ifndef CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package axistream_forwarder_pl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fwd_state_t;

  // One slot per in-flight read plus two for registered capture and head.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/fwd_skid_fifo.sv
// Small register FIFO with first-word-fall-through head and occupancy count;
// absorbs read data that is already in flight when egress stalls.
module fwd_skid_fifo
  import axistream_forwarder_pl_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_din,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_dout,
  output logic                          o_empty,
  output logic [`CLOG2(DEPTH + 1)-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? `CLOG2(DEPTH) : 1;
  localparam int CNT_W = `CLOG2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Push and pop together are accepted even when full or empty (empty case passes through).
  assign w_do_pop  = i_pop && (!o_empty || i_push);
  assign w_do_push = i_push && (!w_full || i_pop);
  assign o_dout    = o_empty ? i_din : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axistream_forwarder_pl.sv
// Streams accepted packets from packet memory to AXI Stream egress with a
// credit-limited read pipeline, exact TKEEP/TLAST and optional snap-length.
module axistream_forwarder_pl
  import axistream_forwarder_pl_pkg::*;
#(
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int PLEN_WIDTH        = 32,
  parameter int RD_LATENCY        = 2,
  parameter int SNAPLEN           = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [SN_FWD_DATA_WIDTH-1:0]   fwd_TDATA,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] fwd_TKEEP,
  output logic                           fwd_TLAST,
  output logic                           fwd_TVALID,
  input  logic                           fwd_TREADY,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   fwd_addr,
  output logic                           fwd_rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   fwd_rd_data,
  input  logic                           fwd_rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]          fwd_byte_len,
  input  logic                           rdy_for_fwd,
  output logic                           rdy_for_fwd_ack,
  output logic                           fwd_done,
  output logic [15:0]                    trunc_count
);

  localparam int BYTES      = SN_FWD_DATA_WIDTH / 8;
  localparam int BYTES_LOG2 = `CLOG2(BYTES);
  localparam int REM_W      = (BYTES_LOG2 > 0) ? BYTES_LOG2 : 1;
  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CNT_W      = `CLOG2(FIFO_DEPTH + 1);
  localparam int FIFO_W     = SN_FWD_DATA_WIDTH + BYTES + 1;

  localparam logic [PLEN_WIDTH-1:0] SNAP_LEN  = PLEN_WIDTH'(SNAPLEN);
  localparam logic [PLEN_WIDTH-1:0] PLEN_ONE  = PLEN_WIDTH'(1);
  localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  fwd_state_t                   r_state;
  fwd_state_t                   w_state_next;
  logic [PLEN_WIDTH-1:0]        r_issued;
  logic [PLEN_WIDTH-1:0]        r_recvd;
  logic [PLEN_WIDTH-1:0]        r_nwords;
  logic [REM_W-1:0]             r_rem;
  logic [CNT_W-1:0]             r_outstanding;
  logic [15:0]                  r_trunc_count;

  logic                         w_truncate;
  logic [PLEN_WIDTH-1:0]        w_len_sel;
  logic [REM_W-1:0]             w_rem_in;
  logic [PLEN_WIDTH-1:0]        w_nwords;
  logic                         w_accept;
  logic                         w_rd_en;
  logic                         w_done;
  logic                         w_credit_ok;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_push_last;
  logic [BYTES-1:0]             w_keep_last;
  logic [BYTES-1:0]             w_keep;
  logic                         w_fifo_empty;
  logic [CNT_W-1:0]             w_fifo_count;
  logic [FIFO_W-1:0]            w_head;
  logic [SN_FWD_DATA_WIDTH-1:0] w_head_data;
  logic [BYTES-1:0]             w_head_keep;
  logic                         w_head_last;
  logic                         w_tlast_done;

  assign w_truncate = (SNAPLEN != 0) && (fwd_byte_len > SNAP_LEN);
  assign w_len_sel  = w_truncate ? SNAP_LEN : fwd_byte_len;

  generate
    if (BYTES_LOG2 == 0) begin : g_rem_none
      assign w_rem_in = '0;
    end else begin : g_rem
      assign w_rem_in = w_len_sel[BYTES_LOG2-1:0];
    end
  endgenerate

  // Shift plus a round-up bit cannot overflow PLEN_WIDTH, unlike len+BYTES-1.
  assign w_nwords = (w_len_sel >> BYTES_LOG2) + PLEN_WIDTH'(w_rem_in != '0);

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
      assign w_keep_last[gi] = (r_rem == '0) || (REM_W'(gi) < r_rem);
    end
  endgenerate

  assign w_push      = fwd_rd_data_vld && (r_outstanding != '0);
  assign w_push_last = (r_recvd == r_nwords - PLEN_ONE);
  assign w_keep      = w_push_last ? w_keep_last : '1;
  assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < DEPTH_C;

  fwd_skid_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_skid_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({w_push_last, w_keep, fwd_rd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head_data  = w_head[SN_FWD_DATA_WIDTH-1:0];
  assign w_head_keep  = w_head[SN_FWD_DATA_WIDTH +: BYTES];
  assign w_head_last  = w_head[FIFO_W-1];
  assign w_pop        = fwd_TVALID && fwd_TREADY;
  assign w_tlast_done = w_pop && w_head_last && (r_outstanding == '0)
                        && (w_fifo_count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rdy_for_fwd) begin
          w_accept     = 1'b1;
          w_state_next = (w_len_sel == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        w_rd_en = (r_issued < r_nwords) && w_credit_ok;
        if (w_rd_en && (r_issued == r_nwords - PLEN_ONE)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_tlast_done) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued      <= '0;
      r_recvd       <= '0;
      r_nwords      <= '0;
      r_rem         <= '0;
      r_outstanding <= '0;
      r_trunc_count <= '0;
    end else begin
      if (w_accept) begin
        r_issued <= '0;
        r_recvd  <= '0;
        r_nwords <= w_nwords;
        r_rem    <= w_rem_in;
        if (w_truncate && (r_trunc_count != 16'hFFFF)) begin
          r_trunc_count <= r_trunc_count + 16'd1;
        end
      end else begin
        if (w_rd_en) begin
          r_issued <= r_issued + PLEN_ONE;
        end
        if (w_push) begin
          r_recvd <= r_recvd + PLEN_ONE;
        end
      end
      case ({w_rd_en, w_push})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Head payload is gated so idle outputs read as zero regardless of FIFO contents.
  assign fwd_TVALID      = !w_fifo_empty;
  assign fwd_TDATA       = fwd_TVALID ? w_head_data : '0;
  assign fwd_TKEEP       = fwd_TVALID ? w_head_keep : '0;
  assign fwd_TLAST       = fwd_TVALID && w_head_last;
  assign fwd_addr        = r_issued[SN_FWD_ADDR_WIDTH-1:0];
  assign fwd_rd_en       = w_rd_en;
  assign rdy_for_fwd_ack = w_accept;
  assign fwd_done        = w_done;
  assign trunc_count     = r_trunc_count;

endmodule

// File: tb/tb_axistream_forwarder_pl.sv
// Self-checking bench: random packet memory, latency-accurate read responder,
// and a per-packet reference of beats, timing and truncation count.
module tb_axistream_forwarder_pl;

  localparam int W          = 64;
  localparam int AW         = 8;
  localparam int PW         = 32;
  localparam int RL         = 4;
  localparam int SNAPLEN    = 1004;
  localparam int BYTES      = W / 8;
  localparam int FIFO_DEPTH = RL + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    fwd_TDATA;
  logic [BYTES-1:0] fwd_TKEEP;
  logic            fwd_TLAST;
  logic            fwd_TVALID;
  logic            fwd_TREADY;
  logic [AW-1:0]   fwd_addr;
  logic            fwd_rd_en;
  logic [W-1:0]    fwd_rd_data;
  logic            fwd_rd_data_vld;
  logic [PW-1:0]   fwd_byte_len;
  logic            rdy_for_fwd;
  logic            rdy_for_fwd_ack;
  logic            fwd_done;
  logic [15:0]     trunc_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_trunc = 0;

  logic [W-1:0]  mem [256];
  logic [RL-1:0] p_vld = '0;
  logic [AW-1:0] p_addr [RL];

  always #5 clk = ~clk;

  axistream_forwarder_pl #(
    .SN_FWD_DATA_WIDTH (W),
    .SN_FWD_ADDR_WIDTH (AW),
    .PLEN_WIDTH        (PW),
    .RD_LATENCY        (RL),
    .SNAPLEN           (SNAPLEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fwd_TDATA       (fwd_TDATA),
    .fwd_TKEEP       (fwd_TKEEP),
    .fwd_TLAST       (fwd_TLAST),
    .fwd_TVALID      (fwd_TVALID),
    .fwd_TREADY      (fwd_TREADY),
    .fwd_addr        (fwd_addr),
    .fwd_rd_en       (fwd_rd_en),
    .fwd_rd_data     (fwd_rd_data),
    .fwd_rd_data_vld (fwd_rd_data_vld),
    .fwd_byte_len    (fwd_byte_len),
    .rdy_for_fwd     (rdy_for_fwd),
    .rdy_for_fwd_ack (rdy_for_fwd_ack),
    .fwd_done        (fwd_done),
    .trunc_count     (trunc_count)
  );

  // Memory responder: data appears exactly RL cycles after the strobe, and is not reset.
  always @(posedge clk) begin
    p_vld     <= {p_vld[RL-2:0], fwd_rd_en};
    p_addr[0] <= fwd_addr;
    for (int k = 1; k < RL; k++) p_addr[k] <= p_addr[k-1];
  end
  assign fwd_rd_data_vld = p_vld[RL-1];
  assign fwd_rd_data     = mem[p_addr[RL-1]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {fwd_TVALID, fwd_TLAST, fwd_TKEEP, fwd_TDATA, fwd_addr, fwd_rd_en,
              rdy_for_fwd_ack, fwd_done, trunc_count}, '0);
  endtask

  // Entered at the negedge of the ack cycle; runs until fwd_done or the cycle budget expires.
  task automatic stream_packet(input int len, input int stall_pct);
    int nw, rem, rd_cnt, beats, t_last;
    bit done_seen, stalled;
    logic [W+BYTES:0] cur, held, expb;
    logic [7:0] kx;
    nw = (len + BYTES - 1) / BYTES;
    rem = len % BYTES;
    rd_cnt = 0; beats = 0; t_last = 0; done_seen = 0; stalled = 0; held = '0;
    for (int c = 1; c <= 40 * nw + 40 && !done_seen; c++) begin
      @(posedge clk); #1;
      rdy_for_fwd = 1'b0;
      fwd_TREADY = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (c == 1 && nw > 0) chk("first_rd_en", fwd_rd_en, 1);
      if (nw == 0) chk("zero_no_valid", fwd_TVALID, 0);
      if (fwd_rd_en) begin
        chk("rd_addr", fwd_addr, rd_cnt);
        rd_cnt++;
        chk("credit_bound", (rd_cnt - beats) <= FIFO_DEPTH, 1);
      end
      cur = {fwd_TDATA, fwd_TKEEP, fwd_TLAST};
      if (stalled) begin
        chk("hold_valid", fwd_TVALID, 1);
        chk("hold_beat", cur, held);
      end
      if (fwd_TVALID && beats == 0 && !stalled) chk("first_valid_cycle", c, 2 + RL);
      if (fwd_TVALID && fwd_TREADY) begin
        kx = (beats == nw - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
        expb = {mem[beats % 256], kx, beats == nw - 1};
        chk("beat", cur, expb);
        if (fwd_TLAST) t_last = c;
        beats++;
      end
      stalled = fwd_TVALID && !fwd_TREADY;
      held = cur;
      if (fwd_done) begin
        done_seen = 1;
        chk("done_cycle", c, (nw == 0) ? 1 : t_last + 1);
      end
    end
    chk("done_seen", done_seen, 1);
    chk("beat_count", beats, nw);
    chk("read_count", rd_cnt, nw);
    chk("trunc_count", trunc_count, exp_trunc);
    $display("packet len=%0d beats=%0d reads=%0d trunc=%0d", len, beats, rd_cnt, trunc_count);
  endtask

  task automatic run_packet(input int blen, input int stall_pct);
    int len;
    len = (SNAPLEN != 0 && blen > SNAPLEN) ? SNAPLEN : blen;
    if (len != blen && exp_trunc < 65535) exp_trunc++;
    @(posedge clk); #1;
    rdy_for_fwd = 1'b1;
    fwd_byte_len = blen;
    fwd_TREADY = 1'b1;
    @(negedge clk);
    chk("ack", rdy_for_fwd_ack, 1);
    stream_packet(len, stall_pct);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rdy_for_fwd = 1'b0;
    fwd_byte_len = '0;
    fwd_TREADY = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_outputs");

    run_packet(20, 0);
    run_packet(64, 0);
    run_packet(1500, 50);
    run_packet(100, 0);

    // Zero-length packet, then a second one held ready back-to-back.
    @(posedge clk); #1;
    rdy_for_fwd = 1'b1;
    fwd_byte_len = 0;
    @(negedge clk);
    chk("zl_ack", rdy_for_fwd_ack, 1);
    @(posedge clk); #1;
    fwd_byte_len = 20;
    @(negedge clk);
    chk("zl_done", fwd_done, 1);
    chk("zl_no_ack", rdy_for_fwd_ack, 0);
    chk("zl_no_valid", fwd_TVALID, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_ack", rdy_for_fwd_ack, 1);
    stream_packet(20, 0);

    for (int i = 0; i < 6; i++) run_packet($urandom_range(0, 2000), $urandom_range(0, 70));

    // Reset in the middle of a packet with reads still in flight.
    @(posedge clk); #1;
    rdy_for_fwd = 1'b1;
    fwd_byte_len = 200;
    fwd_TREADY = 1'b1;
    @(negedge clk);
    chk("mr_ack", rdy_for_fwd_ack, 1);
    @(posedge clk); #1;
    rdy_for_fwd = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_reset_outputs");
    exp_trunc = 0;
    @(posedge clk); #1;
    check_zero("held_reset_outputs");
    rst = 1'b0;
    for (int i = 0; i < RL + 3; i++) begin
      @(negedge clk);
      chk("stale_ignored", {fwd_TVALID, fwd_rd_en, fwd_done}, 0);
    end
    run_packet(40, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
